// File: rtl/register_transfer_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : register_transfer_controller_if
// Description : Handshake/control bundle between the register transfer
//               controller and the processor datapath / address decoder.
//   run            - start request (sampled only while idle)
//   instruction    - opcode | rx | ry, captured when run is accepted
//   write_address  - register write address (decoder address input)
//   write_enable   - register write strobe (decoder enable input)
//   bus_source     - bus mux select: 0..2**REG_WIDTH-1 register,
//                    2**REG_WIDTH DIN, 2**REG_WIDTH+1 G
//   a_load/g_load  - A / G register load strobes
//   add_sub        - ALU operation, 0 add / 1 subtract
//   ir_load        - instruction capture strobe
//   busy/done      - not idle / final cycle of an instruction
//   illegal        - unsupported opcode pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface register_transfer_controller_if #(
  parameter int REG_WIDTH = 3,
  parameter int OP_WIDTH  = 3
);
  localparam int IW = OP_WIDTH + 2 * REG_WIDTH;

  logic                 run;
  logic [IW-1:0]        instruction;
  logic [REG_WIDTH-1:0] write_address;
  logic                 write_enable;
  logic [REG_WIDTH:0]   bus_source;
  logic                 a_load;
  logic                 g_load;
  logic                 add_sub;
  logic                 ir_load;
  logic                 busy;
  logic                 done;
  logic                 illegal;

  // Controller side
  modport master (
    input  run, instruction,
    output write_address, write_enable, bus_source, a_load, g_load,
           add_sub, ir_load, busy, done, illegal
  );

  // Datapath / stimulus side
  modport slave (
    output run, instruction,
    input  write_address, write_enable, bus_source, a_load, g_load,
           add_sub, ir_load, busy, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/register_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module      : register_transfer_controller
// Description : Multi-cycle control unit for the lab processor datapath.
//               Latches an instruction (opcode | rx | ry) and sequences the
//               bus source, A/G loads, ALU operation and register write.
// Ports       : clk - rising-edge clock
//               rst - synchronous active-high reset; forces all outputs low
//               bus - register_transfer_controller_if.master (see interface)
// Revision    : 1.0 - initial release
// ============================================================================
module register_transfer_controller #(
  parameter int REG_WIDTH = 3,
  parameter int OP_WIDTH  = 3
) (
  input  logic clk,
  input  logic rst,
  register_transfer_controller_if.master bus
);
  localparam int IW = OP_WIDTH + 2 * REG_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;

  localparam logic [OP_WIDTH-1:0] OP_MV  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MVI = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(3);

  // Bus selects just above the register range
  localparam logic [REG_WIDTH:0] SRC_DIN = {1'b1, {REG_WIDTH{1'b0}}};
  localparam logic [REG_WIDTH:0] SRC_G   = SRC_DIN + (REG_WIDTH + 1)'(1);

  logic [1:0]           r_state;
  logic [IW-1:0]        r_ir;

  logic [OP_WIDTH-1:0]  w_opcode;
  logic [REG_WIDTH-1:0] w_rx;
  logic [REG_WIDTH-1:0] w_ry;
  logic                 w_is_arith;

  logic                 w_write_enable;
  logic [REG_WIDTH:0]   w_bus_source;
  logic                 w_a_load;
  logic                 w_g_load;
  logic                 w_add_sub;
  logic                 w_ir_load;
  logic                 w_done;
  logic                 w_illegal;

  assign w_opcode   = r_ir[IW-1 -: OP_WIDTH];
  assign w_rx       = r_ir[2*REG_WIDTH-1 -: REG_WIDTH];
  assign w_ry       = r_ir[REG_WIDTH-1:0];
  assign w_is_arith = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

  // State and instruction register; IR only loads in IDLE so a held or
  // changing instruction input has no effect while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run) begin
            r_ir    <= bus.instruction;
            r_state <= S_T1;
          end
        end
        S_T1:    r_state <= w_is_arith ? S_T2 : S_IDLE;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_write_enable = 1'b0;
    w_bus_source   = '0;
    w_a_load       = 1'b0;
    w_g_load       = 1'b0;
    w_add_sub      = 1'b0;
    w_ir_load      = 1'b0;
    w_done         = 1'b0;
    w_illegal      = 1'b0;
    case (r_state)
      S_IDLE: w_ir_load = bus.run;
      S_T1: begin
        case (w_opcode)
          OP_MV: begin
            w_bus_source   = {1'b0, w_ry};
            w_write_enable = 1'b1;
            w_done         = 1'b1;
          end
          OP_MVI: begin
            w_bus_source   = SRC_DIN;
            w_write_enable = 1'b1;
            w_done         = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_bus_source = {1'b0, w_rx};
            w_a_load     = 1'b1;
          end
          default: begin
            w_done    = 1'b1;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_T2: begin
        w_bus_source = {1'b0, w_ry};
        w_g_load     = 1'b1;
        w_add_sub    = w_opcode[0];  // add=...0, sub=...1
      end
      S_T3: begin
        w_bus_source   = SRC_G;
        w_write_enable = 1'b1;
        w_done         = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset is applied combinationally to the outputs as well, so nothing
  // (not even the run-derived ir_load) escapes while rst is held.
  assign bus.write_address = rst ? '0   : w_rx;
  assign bus.write_enable  = rst ? 1'b0 : w_write_enable;
  assign bus.bus_source    = rst ? '0   : w_bus_source;
  assign bus.a_load        = rst ? 1'b0 : w_a_load;
  assign bus.g_load        = rst ? 1'b0 : w_g_load;
  assign bus.add_sub       = rst ? 1'b0 : w_add_sub;
  assign bus.ir_load       = rst ? 1'b0 : w_ir_load;
  assign bus.busy          = rst ? 1'b0 : (r_state != S_IDLE);
  assign bus.done          = rst ? 1'b0 : w_done;
  assign bus.illegal       = rst ? 1'b0 : w_illegal;
endmodule
`default_nettype wire

// File: tb/tb_register_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_transfer_controller
// Description : Self-checking bench for register_transfer_controller.
//               A reference model expands each accepted instruction into
//               its list of per-cycle expected outputs; directed scenarios
//               are followed by randomized run/instruction/reset traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_transfer_controller;
  localparam int RW  = 3;
  localparam int OW  = 3;
  localparam int DIN = 1 << RW;
  localparam int GSRC = (1 << RW) + 1;

  logic clk;
  logic rst;

  register_transfer_controller_if #(.REG_WIDTH(RW), .OP_WIDTH(OW)) bus_if ();

  register_transfer_controller #(.REG_WIDTH(RW), .OP_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bs;
    int we;
    int al;
    int gl;
    int as;
    int done;
    int ill;
  } rec_t;

  rec_t q[$];
  int   m_ir;
  int   errors;
  int   checks;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic rec_t mk(int bs, int we, int al, int gl, int as, int done, int ill);
    rec_t r;
    r.bs = bs; r.we = we; r.al = al; r.gl = gl; r.as = as; r.done = done; r.ill = ill;
    return r;
  endfunction

  // Expected per-cycle outputs for one instruction, derived from the opcode
  // rules by plain arithmetic on the instruction value.
  task automatic push_records(input int ins);
    int op, rx, ry;
    op = ins / 64;
    rx = (ins / 8) % 8;
    ry = ins % 8;
    case (op)
      0: q.push_back(mk(ry, 1, 0, 0, 0, 1, 0));
      1: q.push_back(mk(DIN, 1, 0, 0, 0, 1, 0));
      2, 3: begin
        q.push_back(mk(rx, 0, 1, 0, 0, 0, 0));
        q.push_back(mk(ry, 0, 0, 1, op - 2, 0, 0));
        q.push_back(mk(GSRC, 1, 0, 0, 0, 1, 0));
      end
      default: q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    endcase
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic r, input logic rn, input logic [8:0] ins);
    rec_t e;
    int exp_wa, exp_irl, exp_busy, got_ctrl, exp_ctrl;
    rst = r;
    bus_if.run = rn;
    bus_if.instruction = ins;
    @(negedge clk);
    if (r) begin
      e = mk(0, 0, 0, 0, 0, 0, 0);
      exp_wa = 0; exp_irl = 0; exp_busy = 0;
    end else if (q.size() == 0) begin
      e = mk(0, 0, 0, 0, 0, 0, 0);
      exp_wa = (m_ir / 8) % 8; exp_irl = int'(rn); exp_busy = 0;
    end else begin
      e = q[0];
      exp_wa = (m_ir / 8) % 8; exp_irl = 0; exp_busy = 1;
    end
    exp_ctrl = e.al * 64 + e.gl * 32 + e.as * 16 + exp_irl * 8 + exp_busy * 4
             + e.done * 2 + e.ill;
    got_ctrl = int'({bus_if.a_load, bus_if.g_load, bus_if.add_sub, bus_if.ir_load,
                     bus_if.busy, bus_if.done, bus_if.illegal});
    check("bus_source", int'(bus_if.bus_source), e.bs);
    check("write_address", int'(bus_if.write_address), exp_wa);
    check("write_enable", int'(bus_if.write_enable), e.we);
    check("ctrl{aload,gload,addsub,irload,busy,done,illegal}", got_ctrl, exp_ctrl);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ir = 0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (rn) begin
      m_ir = int'(ins);
      push_records(int'(ins));
    end
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_ir   = 0;
    rst    = 1'b1;
    bus_if.run = 1'b0;
    bus_if.instruction = '0;

    // Reset held for two cycles with run asserted, then idle
    step(1, 1, 9'b111_111_111);
    step(1, 1, 9'b111_111_111);
    step(0, 0, 9'b000_000_000);

    // mv R5,R2
    step(0, 1, 9'b000_101_010);
    step(0, 0, 9'b000_000_000);
    step(0, 0, 9'b000_000_000);

    // sub R1,R6
    step(0, 1, 9'b011_001_110);
    repeat (4) step(0, 0, 9'b000_000_000);

    // add R0,R7 with mvi R4 requested throughout T2/T3 and the next idle
    step(0, 1, 9'b010_000_111);
    step(0, 0, 9'b001_100_000);
    step(0, 1, 9'b001_100_000);
    step(0, 1, 9'b001_100_000);
    step(0, 1, 9'b001_100_000);
    step(0, 0, 9'b000_000_000);
    step(0, 0, 9'b000_000_000);

    // Illegal opcode
    step(0, 1, 9'b111_011_000);
    step(0, 0, 9'b000_000_000);
    step(0, 0, 9'b000_000_000);

    // add R3,R3 (rx == ry) and mv R2,R2
    step(0, 1, 9'b010_011_011);
    repeat (3) step(0, 0, 9'b000_000_000);
    step(0, 1, 9'b000_010_010);
    step(0, 0, 9'b000_000_000);

    // Reset during T2 of add R2,R3, then mvi R7
    step(0, 1, 9'b010_010_011);
    step(0, 0, 9'b000_000_000);
    step(1, 0, 9'b000_000_000);
    step(0, 0, 9'b000_000_000);
    step(0, 1, 9'b001_111_000);
    step(0, 0, 9'b000_000_000);
    step(0, 0, 9'b000_000_000);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic       r, rn;
      logic [8:0] ins;
      r   = ($urandom_range(0, 39) == 0);
      rn  = ($urandom_range(0, 2) != 0);
      ins = 9'($urandom);
      step(r, rn, ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/register_transfer_controller.md
Name: register_transfer_controller

Overview:
Multi-cycle control unit for the lab processor datapath. It latches a 9-bit-class instruction (opcode, Rx, Ry) and sequences the bus source, A/G loads and the ALU operation. It drives the register-file write address and enable that feed the address decoder's In_Address and In_Enable directly. It sits immediately upstream of the address decoder.

Parameters:
P_RegWidth, 3, register address width; the register file has 2**P_RegWidth registers.
P_OpWidth, 3, opcode width.
Derived instruction width IW = P_OpWidth + 2*P_RegWidth. Layout, MSB first: opcode | Rx | Ry.

Ports:
In_Clock  input  1  single clock; all state changes on the rising edge.
In_Reset  input  1  synchronous, active-high reset.
In_Run  input  1  start request; sampled only in IDLE.
In_Instruction  input  IW  instruction word; captured when In_Run is accepted.
Out_WriteAddress  output  P_RegWidth  register write address to the decoder's In_Address.
Out_WriteEnable  output  1  register write strobe to the decoder's In_Enable.
Out_BusSource  output  P_RegWidth+1  bus mux select:
- values 0..2**P_RegWidth-1 select that register;
- 2**P_RegWidth selects DIN;
- 2**P_RegWidth+1 selects G.
Out_ALoad  output  1  load the A register from the bus.
Out_GLoad  output  1  load the G register from the ALU.
Out_AddSub  output  1  ALU operation: 0 = add, 1 = subtract.
Out_IRLoad  output  1  instruction capture strobe (observability).
Out_Busy  output  1  high in any state other than IDLE.
Out_Done  output  1  one-cycle pulse in the final cycle of each instruction.
Out_Illegal  output  1  one-cycle pulse for an unsupported opcode.

Behaviour:
- State register: IDLE, T1, T2, T3. Internal IR register is IW bits wide.
- Outputs are combinational from the state and IR. The only exception is Out_IRLoad = In_Run while in IDLE.
- Reset:
  - State goes to IDLE and IR clears to 0 on the next edge.
  - While In_Reset is high, every output is forced to 0, including Out_IRLoad and Out_WriteEnable.
  - Reset mid-instruction aborts the instruction: no write and no Done.
- Default values for every output not listed in a state: 0. Out_WriteAddress always equals IR.Rx; its reset value is 0.
- IDLE:
  - If In_Run is high, capture In_Instruction into IR and go to T1. Otherwise stay in IDLE.
- T1, by opcode:
  - 000 mv: BusSource = Ry, WriteEnable = 1, Done = 1, next state IDLE.
  - 001 mvi: BusSource = DIN, WriteEnable = 1, Done = 1, next state IDLE.
  - 010 add / 011 sub: BusSource = Rx, ALoad = 1, next state T2.
  - Any other opcode: Done = 1, Illegal = 1, no write, next state IDLE.
- T2: BusSource = Ry, GLoad = 1, AddSub = IR opcode bit 0, next state T3.
- T3: BusSource = G, WriteEnable = 1, Done = 1, next state IDLE.
- Latency, counting from the edge that accepts In_Run:
  - mv, mvi and illegal opcodes complete in 1 cycle (T1).
  - add and sub complete in 3 cycles (T1–T3).
  - The register write happens at the edge that ends the Done cycle.
- In_Run high while Busy is ignored and is not queued. In_Instruction changes while Busy have no effect because IR is held.
- Back-to-back operation: a new instruction is accepted only in IDLE. The minimum issue interval is therefore 2 cycles for mv and 4 cycles for add.
- Rx == Ry is legal:
  - "add R3,R3" doubles R3.
  - "mv R2,R2" still asserts WriteEnable.
- Out_WriteEnable is never high in IDLE or T2, and never high for two consecutive cycles.

Test Plan:
- Reset, then idle: In_Reset high for 2 cycles with In_Run = 1 -> all outputs 0, Busy = 0. After reset releases, IR is still 0 and Out_WriteAddress = 0.
- mv R5,R2 (000_101_010): Run pulse -> next cycle BusSource = 2, WriteAddress = 5, WriteEnable = 1, Done = 1. Following cycle Busy = 0.
- sub R1,R6 (011_001_110): T1 BusSource = 1, ALoad = 1. T2 BusSource = 6, GLoad = 1, AddSub = 1. T3 BusSource = 9 (G), WriteAddress = 1, WriteEnable = 1, Done = 1. Total 3 cycles.
- Run ignored while busy: start add R0,R7, then hold In_Run = 1 with mvi R4 through T2–T3 -> IR unchanged and WriteAddress = 0 at T3. The mvi is accepted only at the IDLE edge after Done.
- Illegal opcode 111_011_000: -> T1 Done = 1, Illegal = 1, WriteEnable = 0, then IDLE.
- Reset during T2 of add R2,R3: -> next cycle IDLE, no WriteEnable, no Done. A subsequent mvi R7 (001_111_000) executes normally with BusSource = 8 (DIN).
